// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage, debug requester and DataMemory signals around dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dbg_ack, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dbg_ack, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU MEM stage has fixed priority, debug/loader accesses fill idle
// cycles, and a starved debug request forces a single CPU stall slot after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  arb_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } dbg_state_e;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    dbg_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              cpu_active;
    logic              cpu_grant;
    logic              dbg_grant;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples the
    // pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which is what keeps this combinational block from inferring latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_if.dbg_req) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    we_d    = arb_if.dbg_we;
                    addr_d  = arb_if.dbg_addr;
                    wdata_d = arb_if.dbg_wdata;
                end
            end
            S_WAIT: begin
                if (dbg_grant) begin
                    state_d = S_ACK;
                    if (!we_q) rdata_d = arb_if.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    // Counter parks here; the stall slot guarantees the grant next cycle.
                    stall_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_active = arb_if.cpu_rd | arb_if.cpu_wr;
        dbg_grant  = stall_q | (~cpu_active & (state_q == S_WAIT));
        cpu_grant  = cpu_active & ~stall_q;

        arb_if.mem_rd    = arb_if.cpu_rd;
        arb_if.mem_wr    = arb_if.cpu_wr;
        arb_if.mem_addr  = arb_if.cpu_addr;
        arb_if.mem_wdata = arb_if.cpu_wdata;
        if (dbg_grant) begin
            arb_if.mem_rd    = ~we_q;
            arb_if.mem_wr    = we_q;
            arb_if.mem_addr  = addr_q;
            arb_if.mem_wdata = wdata_q;
        end

        arb_if.cpu_rdata = cpu_grant ? arb_if.mem_rdata : '0;
        arb_if.cpu_stall = stall_q;
        arb_if.dbg_ack   = (state_q == S_ACK);
        arb_if.dbg_rdata = rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random CPU/debug traffic,
// compared cycle by cycle against a transaction-level model of the sharing rules.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) arb_if ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk    (clk),
        .reset  (reset),
        .arb_if (arb_if)
    );

    // Memory behind the arbiter: 16 words, combinational read, write on the edge.
    logic [31:0] dut_mem [16];
    assign arb_if.mem_rdata = dut_mem[arb_if.mem_addr[5:2]];
    always @(posedge clk) if (arb_if.mem_wr === 1'b1) dut_mem[arb_if.mem_addr[5:2]] <= arb_if.mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding debug transaction, its denial count, and whether the
    // current cycle is a forced slot or an ack cycle.
    logic [31:0] ref_mem [16];
    logic        m_busy = 1'b0, m_forced = 1'b0, m_ack = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    int          m_denied = 0;
    logic        last_stall = 1'b0, last_ack = 1'b0;
    int          wr_seen = 0, stall_seen = 0, ack_seen = 0;

    task automatic cycle(input logic rd, input logic wr, input logic [31:0] ca, input logic [31:0] cw,
                         input logic req, input logic we, input logic [31:0] da, input logic [31:0] dw,
                         input logic rst);
        logic        cpu_act, served, cserved, idle, e_rd, e_wr;
        logic [31:0] e_addr, e_wdata, e_crd, rd_word;
        arb_if.cpu_rd = rd;   arb_if.cpu_wr = wr;   arb_if.cpu_addr = ca; arb_if.cpu_wdata = cw;
        arb_if.dbg_req = req; arb_if.dbg_we = we;   arb_if.dbg_addr = da; arb_if.dbg_wdata = dw;
        reset = rst;
        #2;
        cpu_act = rd | wr;
        served  = m_busy && (m_forced || !cpu_act);
        cserved = cpu_act && !m_forced;
        e_rd    = served ? !m_we   : rd;
        e_wr    = served ? m_we    : wr;
        e_addr  = served ? m_addr  : ca;
        e_wdata = served ? m_wdata : cw;
        e_crd   = cserved ? ref_mem[ca[5:2]] : 32'h0;
        check("cpu_stall", 32'(arb_if.cpu_stall), 32'(m_forced));
        check("dbg_ack",   32'(arb_if.dbg_ack),   32'(m_ack));
        check("dbg_rdata", arb_if.dbg_rdata, m_rdata);
        check("mem_rd",    32'(arb_if.mem_rd),    32'(e_rd));
        check("mem_wr",    32'(arb_if.mem_wr),    32'(e_wr));
        check("mem_addr",  arb_if.mem_addr,  e_addr);
        check("mem_wdata", arb_if.mem_wdata, e_wdata);
        check("cpu_rdata", arb_if.cpu_rdata, e_crd);
        if (arb_if.mem_wr === 1'b1)    wr_seen++;
        if (arb_if.cpu_stall === 1'b1) stall_seen++;
        if (arb_if.dbg_ack === 1'b1)   ack_seen++;
        last_stall = m_forced;
        last_ack   = m_ack;
        @(posedge clk);
        rd_word = ref_mem[e_addr[5:2]];
        if (e_wr) ref_mem[e_addr[5:2]] = e_wdata;
        if (rst) begin
            m_busy = 1'b0; m_forced = 1'b0; m_ack = 1'b0; m_rdata = '0; m_denied = 0;
        end else begin
            idle     = !m_busy && !m_ack;
            m_forced = 1'b0;
            if (served) begin
                if (!m_we) m_rdata = rd_word;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_denied++;
                if (m_denied == MW) m_forced = 1'b1;
            end
            m_ack = served;
            if (idle && req) begin
                m_busy = 1'b1; m_denied = 0; m_we = we; m_addr = da; m_wdata = dw;
            end
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    // Holds a debug request until its ack; CPU mode 0 idle, 1 reads, 2 writes in cycles 1..ncpu.
    task automatic dbg_txn(input logic we, input logic [31:0] a, input logic [31:0] w,
                           input int mode, input int ncpu, output int lat);
        logic ack_now, busy;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            ack_now = m_ack;
            busy    = (k >= 1) && (k <= ncpu);
            cycle(busy && mode == 1, busy && mode == 2, 32'h100 + 32'(k * 4), $urandom,
                  1'b1, we, a, w, 1'b0);
            if (ack_now) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int lat;
        int pct;
        logic        c_rd, c_wr, r_req, r_we, rst;
        logic [31:0] c_a, c_w, r_a, r_w;

        for (int i = 0; i < 16; i++) begin
            dut_mem[i] = 32'h0101_0101 * i;
            ref_mem[i] = 32'h0101_0101 * i;
        end
        arb_if.cpu_rd = 0; arb_if.cpu_wr = 0; arb_if.cpu_addr = '0; arb_if.cpu_wdata = '0;
        arb_if.dbg_req = 0; arb_if.dbg_we = 0; arb_if.dbg_addr = '0; arb_if.dbg_wdata = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles with a request pending, then WAIT entered on first edge after release.
        cycle(0, 0, '0, '0, 1, 0, 32'h10, '0, 1);
        cycle(0, 0, '0, '0, 1, 0, 32'h10, '0, 1);
        dbg_txn(1'b0, 32'h10, '0, 0, 0, lat);
        check("reset_release_latency", 32'(lat), 32'd2);
        idle_cycles(1);

        // Idle debug write then read.
        wr_seen = 0;
        dbg_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, lat);
        check("idle_write_latency", 32'(lat), 32'd2);
        check("idle_write_pulses", 32'(wr_seen), 32'd1);
        idle_cycles(1);
        dbg_txn(1'b0, 32'h10, '0, 0, 0, lat);
        check("idle_read_latency", 32'(lat), 32'd2);
        check("idle_read_data", arb_if.dbg_rdata, 32'hDEAD_BEEF);
        idle_cycles(1);

        // CPU priority: three CPU reads delay the debug read, no stall.
        stall_seen = 0;
        dbg_txn(1'b0, 32'h24, '0, 1, 3, lat);
        check("priority_latency", 32'(lat), 32'd5);
        check("priority_stalls", 32'(stall_seen), 32'd0);
        idle_cycles(1);

        // Starvation with continuous CPU writes.
        stall_seen = 0;
        dbg_txn(1'b1, 32'h38, 32'hCAFE_F00D, 2, 30, lat);
        check("starve_latency", 32'(lat), 32'(MW + 2));
        check("starve_stalls", 32'(stall_seen), 32'd1);
        idle_cycles(1);

        // Request held through ack: each transaction acked once, next one accepted in IDLE.
        ack_seen = 0;
        for (int k = 0; k < 8; k++) cycle(0, 0, '0, '0, 1, k[0], 32'h40 + 32'(k * 4), $urandom, 0);
        check("b2b_acks", 32'(ack_seen), 32'd2);
        idle_cycles(3);

        // Reset mid-WAIT with five denials counted: request abandoned.
        cycle(0, 0, '0, '0, 1, 1, 32'h08, 32'h1234_5678, 0);
        for (int k = 0; k < 5; k++) cycle(1, 0, 32'h04, '0, 1, 1, 32'h08, 32'h1234_5678, 0);
        cycle(1, 0, 32'h04, '0, 1, 1, 32'h08, 32'h1234_5678, 1);
        stall_seen = 0; ack_seen = 0; wr_seen = 0;
        for (int k = 0; k < 12; k++) cycle(1, 0, 32'h04, '0, 0, 0, '0, '0, 0);
        check("abandon_stalls", 32'(stall_seen), 32'd0);
        check("abandon_acks", 32'(ack_seen), 32'd0);
        check("abandon_writes", 32'(wr_seen), 32'd0);
        idle_cycles(1);

        // Reset landing in the forced stall slot.
        cycle(0, 0, '0, '0, 1, 0, 32'h0C, '0, 0);
        stall_seen = 0;
        for (int k = 0; k < 14; k++) begin
            rst = m_forced;
            cycle(0, 1, 32'h2C, $urandom, !rst && stall_seen == 0, 0, 32'h0C, '0, rst);
        end
        check("reset_on_stall_count", 32'(stall_seen), 32'd1);
        idle_cycles(2);

        // Random traffic.
        c_rd = 0; c_wr = 0; c_a = '0; c_w = '0; r_req = 0; r_we = 0; r_a = '0; r_w = '0; pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 30;
                    2: pct = 70;
                    default: pct = 100;
                endcase
            end
            if (!last_stall) begin
                c_rd = $urandom_range(0, 99) < pct;
                c_wr = $urandom_range(0, 99) < pct / 2;
                c_a  = $urandom;
                c_w  = $urandom;
            end
            if (last_ack) begin
                if ($urandom_range(0, 1) == 0) r_req = 0;
                else begin r_we = $urandom_range(0, 1); r_a = $urandom; r_w = $urandom; end
            end else if (!r_req && $urandom_range(0, 3) == 0) begin
                r_req = 1; r_we = $urandom_range(0, 1); r_a = $urandom; r_w = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            if (m_busy) cycle(c_rd, c_wr, c_a, c_w, r_req, $urandom_range(0, 1), $urandom, $urandom, rst);
            else        cycle(c_rd, c_wr, c_a, c_w, r_req, r_we, r_a, r_w, rst);
            if (rst) r_req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the CPU MEM stage and a debug/loader requester (board UART loader, memory dump logic). The CPU has fixed priority; debug accesses fill idle MEM cycles. A starvation counter forces a one-cycle CPU stall slot when debug has waited MAX_WAIT cycles. Sits between the EX/MEM pipeline register outputs and the DataMemory instance.

## Interface
- ADDR_W, 32, address width on all three sides
- DATA_W, 32, data width on all three sides
- MAX_WAIT, 8, denied cycles tolerated in WAIT before a forced slot (legal range 1..255)

- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock, all state cleared
- cpu_rd  input  1  MEM-stage read (MemRead_MEM)
- cpu_wr  input  1  MEM-stage write (MemWrite_MEM)
- cpu_addr  input  ADDR_W  MEM-stage address (ALUOut_MEM)
- cpu_wdata  input  DATA_W  MEM-stage store data
- cpu_rdata  output  DATA_W  load data to MEM/WB register
- cpu_stall  output  1  registered; 1 = MEM stage must hold (freeze PC, IF/ID, ID/EX, EX/MEM)
- dbg_req  input  1  level request, held until dbg_ack
- dbg_we  input  1  1 = write, 0 = read; sampled with request
- dbg_addr  input  ADDR_W  debug address; sampled with request
- dbg_wdata  input  DATA_W  debug write data; sampled with request
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  DATA_W  read data, valid while dbg_ack=1, held until next ack
- mem_rd  output  1  to DataMemory MemRead
- mem_wr  output  1  to DataMemory MemWrite
- mem_addr  output  ADDR_W  to DataMemory Address
- mem_wdata  output  DATA_W  to DataMemory Write_data
- mem_rdata  input  DATA_W  from DataMemory Read_data (combinational read)

## Operation
- Debug FSM states: IDLE, WAIT, ACK.
  - IDLE: dbg_req=1 -> latch dbg_we/addr/wdata, go WAIT, wait counter := 0.
  - WAIT: if granted this cycle -> access performed this cycle, capture mem_rdata into dbg_rdata if read, go ACK; else counter += 1.
  - ACK: dbg_ack=1 for this cycle only -> IDLE. A still-high dbg_req in ACK is ignored; it is re-sampled in IDLE as a new request.
- Grant (combinational, per cycle):
  - cpu_stall=1 -> debug granted (only possible in WAIT).
  - else cpu_rd|cpu_wr -> CPU granted; mem_* driven from cpu_*.
  - else state WAIT -> debug granted; mem_* driven from latched debug fields.
  - else mem_rd=mem_wr=0, mem_addr/mem_wdata = cpu_* (don't-care, no strobes).
- Starvation: in WAIT, when denied and counter == MAX_WAIT-1, cpu_stall := 1 on next edge. cpu_stall stays 1 for exactly one cycle, then 0. cpu_stall only asserts out of WAIT.
- During a stall cycle: CPU pipeline holds, its MEM request repeats next cycle; cpu_rdata = 0.
- cpu_rdata = mem_rdata whenever CPU granted; 0 otherwise.
- cpu_rd and cpu_wr both 1: both strobes forwarded unchanged; arbiter does not arbitrate within CPU.
- Counter width 8 bits; it never passes MAX_WAIT-1, so it never wraps.

## Timing
- Reset values: state IDLE, counter 0, cpu_stall 0, dbg_ack 0, dbg_rdata 0; mem_rd/mem_wr follow cpu_rd/cpu_wr combinationally.
- Debug latency, CPU idle: req sampled at edge N, access in cycle N+1, dbg_ack high in cycle N+2.
- Debug latency, CPU busy every cycle: ack at cycle N+MAX_WAIT+2 (MAX_WAIT denied cycles, stall slot, ACK).
- CPU access: zero added latency, except one lost cycle per forced slot.
- Back-to-back debug: req held through ack -> next access no earlier than ack+2 cycles.
- Reset mid-transaction (WAIT or ACK): request abandoned, no ack issued, no memory strobe after reset edge; requester must re-raise dbg_req.
- Reset coinciding with cpu_stall=1: cpu_stall is 0 in the next cycle.

## Test plan
- Reset: hold reset 2 cycles with dbg_req=1 -> dbg_ack=0, cpu_stall=0, dbg_rdata=0; WAIT entered only on first edge after release.
- Idle debug write then read: write 0xDEADBEEF to 0x10, read 0x10 with CPU idle -> each ack two cycles after request edge, dbg_rdata=0xDEADBEEF, mem_wr pulses exactly once.
- CPU priority: cpu_rd every cycle for 3 cycles, debug read pending -> CPU granted all 3, debug access on 4th cycle, ack on 5th, no cpu_stall.
- Starvation, MAX_WAIT=8: cpu_wr continuous -> cpu_stall high exactly one cycle after 8 denials, debug write lands in that cycle, ack next cycle, CPU write repeated after stall.
- Simultaneous: debug in WAIT and CPU idle in same cycle as req held through ACK -> one ack per transaction, second request accepted in following IDLE.
- Reset mid-WAIT: assert reset with counter=5 -> no ack, counter 0, cpu_stall never asserted for abandoned request.
